// File: rtl/usr_pkg.sv
// usr_pkg: operation encodings for universal_shift_register
package usr_pkg;
  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_LOAD = 3'b001,
    MODE_SHL  = 3'b010,
    MODE_SHR  = 3'b011,
    MODE_ROL  = 3'b100,
    MODE_ROR  = 3'b101,
    MODE_INC  = 3'b110,
    MODE_DEC  = 3'b111
  } mode_t;
endpackage

// File: rtl/universal_shift_register.sv
// universal_shift_register: WIDTH-bit load/shift/rotate/count register; USR_SATURATE_EN saturates INC/DEC
module universal_shift_register
  import usr_pkg::*;
#(
  parameter int              WIDTH        = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE  = '0,
  parameter logic [WIDTH-1:0] PRESET_VALUE = '1
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic             Enable,
  input  logic             Preset,
  input  logic             Clear,
  input  logic [2:0]       Mode,
  input  logic [WIDTH-1:0] D,
  input  logic             Serial_In_L,
  input  logic             Serial_In_R,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Q_bar,
  output logic             Carry,
  output logic             Terminal
);
  logic [WIDTH-1:0] nxt_q;
  logic             nxt_c;
  logic [WIDTH:0]   inc, dec;
  logic             all_ones, zero;
  assign all_ones = &Q;
  assign zero     = ~|Q;
  assign inc      = {1'b0, Q} + {{WIDTH{1'b0}}, 1'b1};
  assign dec      = {1'b0, Q} - {{WIDTH{1'b0}}, 1'b1};
  assign Terminal = (mode_t'(Mode) == MODE_INC && all_ones) || (mode_t'(Mode) == MODE_DEC && zero);
  always_comb begin
    nxt_q = Q;
    nxt_c = Carry;
    case (mode_t'(Mode))
      MODE_LOAD: begin nxt_q = D; nxt_c = 1'b0; end
      MODE_SHL:  begin nxt_q = {Q[WIDTH-2:0], Serial_In_L}; nxt_c = Q[WIDTH-1]; end
      MODE_SHR:  begin nxt_q = {Serial_In_R, Q[WIDTH-1:1]}; nxt_c = Q[0]; end
      MODE_ROL:  begin nxt_q = {Q[WIDTH-2:0], Q[WIDTH-1]}; nxt_c = Q[WIDTH-1]; end
      MODE_ROR:  begin nxt_q = {Q[0], Q[WIDTH-1:1]}; nxt_c = Q[0]; end
`ifdef USR_SATURATE_EN
      MODE_INC:  begin nxt_q = all_ones ? Q : inc[WIDTH-1:0]; nxt_c = all_ones; end
      MODE_DEC:  begin nxt_q = zero ? Q : dec[WIDTH-1:0]; nxt_c = zero; end
`else
      MODE_INC:  begin nxt_q = inc[WIDTH-1:0]; nxt_c = inc[WIDTH]; end
      MODE_DEC:  begin nxt_q = dec[WIDTH-1:0]; nxt_c = dec[WIDTH]; end
`endif
      default: ;
    endcase
  end
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      Q     <= RESET_VALUE;
      Q_bar <= ~RESET_VALUE;
      Carry <= 1'b0;
    end else if (Preset) begin
      Q     <= PRESET_VALUE;
      Q_bar <= ~PRESET_VALUE;
      Carry <= 1'b0;
    end else if (Clear) begin
      Q     <= '0;
      Q_bar <= '1;
      Carry <= 1'b0;
    end else if (Enable) begin
      Q     <= nxt_q;
      Q_bar <= ~nxt_q;
      Carry <= nxt_c;
    end
  end
endmodule

// File: tb/tb_universal_shift_register.sv
// tb_universal_shift_register: directed vectors against hand-computed results
module tb_universal_shift_register;
  import usr_pkg::*;
  logic       clk = 1'b0;
  logic       rst_n, en, pre, clr, sil, sir;
  logic [2:0] mode;
  logic [7:0] d, q, q_bar;
  logic       carry, term;
  int         n_run = 0, n_fail = 0;
  universal_shift_register #(.WIDTH(8), .RESET_VALUE(8'hA5), .PRESET_VALUE(8'hFF)) dut (
    .Clock(clk), .Reset_n(rst_n), .Enable(en), .Preset(pre), .Clear(clr), .Mode(mode),
    .D(d), .Serial_In_L(sil), .Serial_In_R(sir), .Q(q), .Q_bar(q_bar), .Carry(carry),
    .Terminal(term)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic op(input logic [2:0] m, input logic [7:0] dv);
    en = 1'b1; mode = m; d = dv;
    step();
  endtask
  initial begin
    rst_n = 1'b1; en = 1'b0; pre = 1'b0; clr = 1'b0; sil = 1'b0; sir = 1'b0;
    mode = MODE_HOLD; d = '0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_q", q, 8'hA5);
    check("rst_qbar", q_bar, 8'h5A);
    check("rst_carry", carry, 0);
    step();
    rst_n = 1'b1;
    step();
    check("post_rst_q", q, 8'hA5);
    check("hold_term", term, 0);
    op(MODE_LOAD, 8'h81);
    check("load_q", q, 8'h81);
    check("load_carry", carry, 0);
    op(MODE_SHL, 8'h00);
    check("shl1_q", q, 8'h02);
    check("shl1_carry", carry, 1);
    op(MODE_SHL, 8'h00);
    check("shl2_q", q, 8'h04);
    check("shl2_carry", carry, 0);
    check("shl2_qbar", q_bar, 8'hFB);
    op(MODE_LOAD, 8'h02);
    sir = 1'b1;
    op(MODE_SHR, 8'h00);
    sir = 1'b0;
    check("shr_q", q, 8'h81);
    check("shr_carry", carry, 0);
    op(MODE_LOAD, 8'h01);
    op(MODE_ROR, 8'h00);
    check("ror_q", q, 8'h80);
    check("ror_carry", carry, 1);
    op(MODE_ROL, 8'h00);
    check("rol_q", q, 8'h01);
    check("rol_carry", carry, 1);
    op(MODE_HOLD, 8'h00);
    check("mode_hold_q", q, 8'h01);
    check("mode_hold_carry", carry, 1);
    op(MODE_LOAD, 8'hFE);
    mode = MODE_INC;
    #1 check("inc_term_fe", term, 0);
    op(MODE_INC, 8'h00);
    check("inc1_q", q, 8'hFF);
    check("inc1_carry", carry, 0);
    check("inc1_term", term, 1);
    op(MODE_INC, 8'h00);
`ifdef USR_SATURATE_EN
    check("inc2_q", q, 8'hFF);
`else
    check("inc2_q", q, 8'h00);
`endif
    check("inc2_carry", carry, 1);
    op(MODE_LOAD, 8'h00);
    mode = MODE_DEC;
    #1 check("dec_term_00", term, 1);
    op(MODE_DEC, 8'h00);
`ifdef USR_SATURATE_EN
    check("dec_q", q, 8'h00);
`else
    check("dec_q", q, 8'hFF);
`endif
    check("dec_carry", carry, 1);
    en = 1'b0; pre = 1'b1; clr = 1'b1; mode = MODE_DEC;
    step();
    check("preclr_q", q, 8'hFF);
    check("preclr_qbar", q_bar, 8'h00);
    check("preclr_carry", carry, 0);
    pre = 1'b0;
    step();
    check("clr_q", q, 8'h00);
    clr = 1'b0;
    op(MODE_LOAD, 8'h10);
    en = 1'b0; mode = MODE_INC;
    for (int i = 0; i < 3; i++) begin
      step();
      check("en0_q", q, 8'h10);
      check("en0_term", term, 0);
      check("en0_qbar", q_bar, 8'hEF);
    end
    clr = 1'b1;
    op(MODE_LOAD, 8'h55);
    check("clr_over_en_q", q, 8'h00);
    clr = 1'b0;
    op(MODE_INC, 8'h00);
    op(MODE_INC, 8'h00);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_q", q, 8'hA5);
    check("midrst_carry", carry, 0);
    step();
    rst_n = 1'b1;
    mode = MODE_HOLD;
    step();
    check("after_midrst_q", q, 8'hA5);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
